// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types and helpers for the traffic intersection controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2,
        WALK   = 2'd3
    } phase_t;

    // Phase duration in ticks; durations are passed in because they are instance parameters.
    function automatic int phase_ticks(phase_t p, int g, int y, int a, int w);
        case (p)
            GREEN:   phase_ticks = g;
            YELLOW:  phase_ticks = y;
            ALLRED:  phase_ticks = a;
            default: phase_ticks = w;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Loadable down-counter advanced by the timebase tick; done flags the final tick of a phase.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= RST_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = tick && (r_count == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin intersection controller: green/yellow/all-red per approach, optional walk at end of round.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIRS     = 2,
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 10,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 8,
    parameter int ACTUATED     = 0,
    localparam int DIR_W       = $clog2(NUM_DIRS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                ped_button,
    input  logic [NUM_DIRS-1:0] veh_demand,
    output logic [NUM_DIRS-1:0] green,
    output logic [NUM_DIRS-1:0] yellow,
    output logic [NUM_DIRS-1:0] red,
    output logic                ped_walk,
    output logic                ped_pending,
    output logic [DIR_W-1:0]    cur_dir,
    output logic                new_cycle
);

    phase_t             r_phase;
    logic [DIR_W-1:0]   r_cur_dir;
    logic               r_ped_pending;
    logic               r_new_cycle;

    logic               w_done;
    logic               w_nxt_found;
    logic [DIR_W-1:0]   w_scan_dir;
    phase_t             w_nxt_phase;
    logic [DIR_W-1:0]   w_nxt_dir;
    logic [CNT_W-1:0]   w_load_val;
    logic [NUM_DIRS-1:0] w_sel;

    // Lowest served index above cur_dir; scanning downward leaves the lowest match.
    always_comb begin
        w_nxt_found = 1'b0;
        w_scan_dir  = '0;
        for (int j = NUM_DIRS - 1; j >= 0; j--) begin
            if (j > int'(r_cur_dir) && (ACTUATED == 0 || veh_demand[j])) begin
                w_nxt_found = 1'b1;
                w_scan_dir  = DIR_W'(j);
            end
        end
    end

    always_comb begin
        w_nxt_phase = r_phase;
        w_nxt_dir   = r_cur_dir;
        case (r_phase)
            GREEN:  w_nxt_phase = YELLOW;
            YELLOW: w_nxt_phase = ALLRED;
            ALLRED: begin
                if (w_nxt_found) begin
                    w_nxt_phase = GREEN;
                    w_nxt_dir   = w_scan_dir;
                end else begin
                    w_nxt_phase = r_ped_pending ? WALK : GREEN;
                    w_nxt_dir   = '0;
                end
            end
            default: begin
                w_nxt_phase = GREEN;
                w_nxt_dir   = '0;
            end
        endcase
        w_load_val = CNT_W'(phase_ticks(w_nxt_phase, GREEN_TICKS, YELLOW_TICKS,
                                        ALLRED_TICKS, WALK_TICKS) - 1);
    end

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(GREEN_TICKS - 1))
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_done),
        .load_val (w_load_val),
        .tick     (tick),
        .done     (w_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase       <= GREEN;
            r_cur_dir     <= '0;
            r_ped_pending <= 1'b0;
            r_new_cycle   <= 1'b0;
        end else begin
            r_new_cycle <= 1'b0;
            if (w_done) begin
                r_phase     <= w_nxt_phase;
                r_cur_dir   <= w_nxt_dir;
                r_new_cycle <= (w_nxt_phase == GREEN) && (w_nxt_dir == '0);
            end
            // Entering WALK consumes the request even if the button is still held.
            if (w_done && w_nxt_phase == WALK) begin
                r_ped_pending <= 1'b0;
            end else if (ped_button && r_phase != WALK) begin
                r_ped_pending <= 1'b1;
            end
        end
    end

    assign w_sel       = NUM_DIRS'(1) << r_cur_dir;
    assign green       = (r_phase == GREEN)  ? w_sel : '0;
    assign yellow      = (r_phase == YELLOW) ? w_sel : '0;
    assign red         = ~(green | yellow);
    assign ped_walk    = (r_phase == WALK);
    assign ped_pending = r_ped_pending;
    assign cur_dir     = r_cur_dir;
    assign new_cycle   = r_new_cycle;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed checks of the intersection controller: round timing, walk phase, actuation, reset and tick gating.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b1;
    logic       ped_button = 1'b0;

    logic [1:0] veh_demand = 2'b11;
    logic [1:0] green, yellow, red;
    logic       ped_walk, ped_pending, new_cycle;
    logic       cur_dir;

    logic [2:0] veh_a = 3'b000;
    logic [2:0] green_a, yellow_a, red_a;
    logic       ped_walk_a, ped_pending_a, new_cycle_a;
    logic [1:0] cur_dir_a;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .NUM_DIRS(2), .CNT_W(8), .GREEN_TICKS(4), .YELLOW_TICKS(2),
        .ALLRED_TICKS(1), .WALK_TICKS(3), .ACTUATED(0)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .ped_button(ped_button),
        .veh_demand(veh_demand), .green(green), .yellow(yellow), .red(red),
        .ped_walk(ped_walk), .ped_pending(ped_pending), .cur_dir(cur_dir),
        .new_cycle(new_cycle)
    );

    traffic_light_ctrl #(
        .NUM_DIRS(3), .CNT_W(8), .GREEN_TICKS(4), .YELLOW_TICKS(2),
        .ALLRED_TICKS(1), .WALK_TICKS(3), .ACTUATED(1)
    ) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .ped_button(1'b0),
        .veh_demand(veh_a), .green(green_a), .yellow(yellow_a), .red(red_a),
        .ped_walk(ped_walk_a), .ped_pending(ped_pending_a), .cur_dir(cur_dir_a),
        .new_cycle(new_cycle_a)
    );

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves both DUTs at k=0: first clock of green[0] with timer freshly loaded.
    task automatic do_reset();
        reset = 1'b1;
        ped_button = 1'b0;
        tick = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        nchecks++;
        if (green !== 2'b01 || yellow !== 2'b00 || red !== 2'b10) begin
            nerrors++;
            $display("FAIL reset_lamps: g=%b y=%b r=%b, want g=01 y=00 r=10", green, yellow, red);
        end
        nchecks++;
        if (ped_walk !== 1'b0 || ped_pending !== 1'b0 || new_cycle !== 1'b0 || cur_dir !== 1'b0) begin
            nerrors++;
            $display("FAIL reset_flags: walk=%b pend=%b nc=%b dir=%b, want all 0",
                     ped_walk, ped_pending, new_cycle, cur_dir);
        end
        reset = 1'b0;
    endtask

    task automatic test_round();
        logic [1:0] eg[15] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
                               2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
        logic [1:0] ey[15] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00,
                               2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
        logic [1:0] er;
        int lit;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            if (k > 0) step(1);
            er = ~(eg[k] | ey[k]);
            nchecks++;
            if (green !== eg[k] || yellow !== ey[k] || red !== er) begin
                nerrors++;
                $display("FAIL round_lamps k=%0d: g=%b y=%b r=%b, want g=%b y=%b r=%b",
                         k, green, yellow, red, eg[k], ey[k], er);
            end
            nchecks++;
            if (new_cycle !== (k == 14)) begin
                nerrors++;
                $display("FAIL round_new_cycle k=%0d: got %b want %b", k, new_cycle, (k == 14));
            end
            lit = 0;
            for (int d = 0; d < 2; d++) begin
                if (int'(green[d]) + int'(yellow[d]) + int'(red[d]) != 1) lit = 99;
                if (!red[d]) lit++;
            end
            nchecks++;
            if (lit > 1) begin
                nerrors++;
                $display("FAIL round_invariant k=%0d: g=%b y=%b r=%b", k, green, yellow, red);
            end
        end
    endtask

    task automatic test_ped_walk();
        do_reset();
        step(7);
        nchecks++;
        if (cur_dir !== 1'b1 || green !== 2'b10) begin
            nerrors++;
            $display("FAIL ped_pre_green1: dir=%b g=%b, want dir=1 g=10", cur_dir, green);
        end
        ped_button = 1'b1;
        step(1);
        ped_button = 1'b0;
        nchecks++;
        if (ped_pending !== 1'b1) begin
            nerrors++;
            $display("FAIL ped_pending_set: got %b want 1", ped_pending);
        end
        step(5);
        nchecks++;
        if (red !== 2'b11 || ped_walk !== 1'b0 || ped_pending !== 1'b1) begin
            nerrors++;
            $display("FAIL ped_allred: r=%b walk=%b pend=%b, want r=11 walk=0 pend=1",
                     red, ped_walk, ped_pending);
        end
        for (int k = 14; k < 17; k++) begin
            step(1);
            nchecks++;
            if (ped_walk !== 1'b1 || red !== 2'b11 || ped_pending !== 1'b0 || new_cycle !== 1'b0) begin
                nerrors++;
                $display("FAIL ped_walk k=%0d: walk=%b r=%b pend=%b nc=%b, want walk=1 r=11 pend=0 nc=0",
                         k, ped_walk, red, ped_pending, new_cycle);
            end
        end
        step(1);
        nchecks++;
        if (green !== 2'b01 || new_cycle !== 1'b1 || ped_walk !== 1'b0) begin
            nerrors++;
            $display("FAIL ped_after_walk: g=%b nc=%b walk=%b, want g=01 nc=1 walk=0",
                     green, new_cycle, ped_walk);
        end
    endtask

    task automatic test_ped_held_in_walk();
        int walks;
        do_reset();
        step(7);
        ped_button = 1'b1;
        step(1);
        ped_button = 1'b0;
        step(6);
        ped_button = 1'b1;
        nchecks++;
        if (ped_walk !== 1'b1) begin
            nerrors++;
            $display("FAIL held_walk_entry: walk=%b want 1", ped_walk);
        end
        step(3);
        ped_button = 1'b0;
        nchecks++;
        if (ped_pending !== 1'b0 || green !== 2'b01) begin
            nerrors++;
            $display("FAIL held_after_walk: pend=%b g=%b, want pend=0 g=01", ped_pending, green);
        end
        walks = 0;
        for (int k = 18; k <= 31; k++) begin
            step(1);
            if (ped_walk) walks++;
        end
        nchecks++;
        if (walks != 0 || green !== 2'b01 || new_cycle !== 1'b1) begin
            nerrors++;
            $display("FAIL held_next_round: walk_clks=%0d g=%b nc=%b, want 0 01 1", walks, green, new_cycle);
        end
    endtask

    task automatic test_actuated();
        int pulses;
        veh_a = 3'b100;
        do_reset();
        nchecks++;
        if (green_a !== 3'b001) begin
            nerrors++;
            $display("FAIL act_k0: g=%b want 001", green_a);
        end
        step(7);
        nchecks++;
        if (green_a !== 3'b100 || cur_dir_a !== 2'd2) begin
            nerrors++;
            $display("FAIL act_skip_dir1: g=%b dir=%0d, want 100 2", green_a, cur_dir_a);
        end
        step(7);
        nchecks++;
        if (green_a !== 3'b001 || new_cycle_a !== 1'b1) begin
            nerrors++;
            $display("FAIL act_back_dir0: g=%b nc=%b, want 001 1", green_a, new_cycle_a);
        end
        veh_a = 3'b000;
        step(4);
        nchecks++;
        if (yellow_a !== 3'b001) begin
            nerrors++;
            $display("FAIL act_idle_yellow: y=%b want 001", yellow_a);
        end
        step(2);
        nchecks++;
        if (red_a !== 3'b111) begin
            nerrors++;
            $display("FAIL act_idle_allred: r=%b want 111", red_a);
        end
        pulses = 0;
        for (int k = 21; k <= 28; k++) begin
            step(1);
            if (new_cycle_a) pulses++;
            if (k == 21 || k == 28) begin
                nchecks++;
                if (new_cycle_a !== 1'b1 || green_a !== 3'b001) begin
                    nerrors++;
                    $display("FAIL act_idle_regreen k=%0d: nc=%b g=%b, want 1 001", k, new_cycle_a, green_a);
                end
            end
        end
        nchecks++;
        if (pulses != 2) begin
            nerrors++;
            $display("FAIL act_idle_pulse_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_mid_phase();
        do_reset();
        step(1);
        ped_button = 1'b1;
        step(1);
        ped_button = 1'b0;
        step(2);
        nchecks++;
        if (yellow !== 2'b01 || ped_pending !== 1'b1) begin
            nerrors++;
            $display("FAIL midrst_pre: y=%b pend=%b, want 01 1", yellow, ped_pending);
        end
        reset = 1'b1;
        #1;
        nchecks++;
        if (green !== 2'b01 || yellow !== 2'b00 || ped_pending !== 1'b0) begin
            nerrors++;
            $display("FAIL midrst_immediate: g=%b y=%b pend=%b, want 01 00 0", green, yellow, ped_pending);
        end
        step(1);
        reset = 1'b0;
        step(3);
        nchecks++;
        if (green !== 2'b01) begin
            nerrors++;
            $display("FAIL midrst_full_green: g=%b want 01", green);
        end
        step(1);
        nchecks++;
        if (yellow !== 2'b01) begin
            nerrors++;
            $display("FAIL midrst_green_end: y=%b want 01", yellow);
        end
    endtask

    task automatic test_tick_gating();
        int bad;
        do_reset();
        step(1);
        tick = 1'b0;
        ped_button = 1'b1;
        step(1);
        ped_button = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            if (green !== 2'b01 || yellow !== 2'b00 || new_cycle !== 1'b0) bad++;
        end
        nchecks++;
        if (bad != 0 || ped_pending !== 1'b1) begin
            nerrors++;
            $display("FAIL tick_hold: bad_clks=%0d pend=%b, want 0 1", bad, ped_pending);
        end
        tick = 1'b1;
        step(2);
        nchecks++;
        if (green !== 2'b01) begin
            nerrors++;
            $display("FAIL tick_resume_green: g=%b want 01", green);
        end
        step(1);
        nchecks++;
        if (yellow !== 2'b01) begin
            nerrors++;
            $display("FAIL tick_resume_yellow: y=%b want 01", yellow);
        end
    endtask

    initial begin
        test_reset();
        test_round();
        test_ped_walk();
        test_ped_held_in_walk();
        test_actuated();
        test_reset_mid_phase();
        test_tick_gating();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Parametrised, clocked traffic-intersection controller serving NUM_DIRS approaches in round-robin order.
- Each approach gets a green phase, then yellow, then all-red; an optional pedestrian walk phase runs at the end of a round.
- Phase durations are counted in timebase ticks (a 1-clock enable pulse), not raw clocks.
- Optional actuated mode skips side approaches with no vehicle demand. The block sits between the timebase divider and the lamp/ped-signal drivers.

Parameters:
- NUM_DIRS, 2, number of approaches; legal range 2..8; direction 0 is the main street.
- CNT_W, 8, width of the phase timer.
- GREEN_TICKS, 10, green duration in ticks; must be >=1 and < 2**CNT_W.
- YELLOW_TICKS, 3, yellow duration in ticks; same range rule.
- ALLRED_TICKS, 2, all-red clearance in ticks; same range rule.
- WALK_TICKS, 8, pedestrian walk duration in ticks; same range rule.
- ACTUATED, 0, 1 = skip side directions whose veh_demand bit is low.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- tick  input  1  timebase enable; one-clock pulse per time unit.
- ped_button  input  1  pedestrian request, already synchronised, level or pulse.
- veh_demand  input  NUM_DIRS  per-direction vehicle presence; bit 0 is ignored.
- green  output  NUM_DIRS  green lamp per direction.
- yellow  output  NUM_DIRS  yellow lamp per direction.
- red  output  NUM_DIRS  red lamp per direction.
- ped_walk  output  1  walk signal.
- ped_pending  output  1  registered pedestrian request.
- cur_dir  output  $clog2(NUM_DIRS)  direction currently served.
- new_cycle  output  1  one-clock pulse at the start of each round.

Behaviour:
- State: phase in {GREEN, YELLOW, ALLRED, WALK}, plus cur_dir, a down-timer and ped_pending. All are registered; lamps are decoded combinationally from phase and cur_dir.
- Reset (async): phase=GREEN, cur_dir=0, timer=GREEN_TICKS-1, ped_pending=0, new_cycle=0. Outputs during reset: green=1 for direction 0, red=1 for all others, yellow=0, ped_walk=0.
- Phase entry loads timer=DURATION-1. Each clock with tick=1 and timer!=0 decrements the timer. A clock with tick=1 and timer==0 ends the phase. Each phase therefore lasts exactly DURATION ticks. With tick=0 nothing changes except ped_pending.
- Phase transitions:
  - GREEN -> YELLOW, same direction.
  - YELLOW -> ALLRED.
  - ALLRED -> next direction:
    - nxt = lowest index j > cur_dir with (ACTUATED==0 or veh_demand[j]==1), sampled in the transition clock.
    - If nxt exists: GREEN with cur_dir=nxt.
    - If not (end of round): WALK if ped_pending, else GREEN with cur_dir=0.
  - WALK -> GREEN, cur_dir=0.
- Entry into GREEN with cur_dir=0 raises new_cycle for exactly that one clock. Reset itself does not pulse new_cycle.
- Lamp decoding:
  - GREEN: green[cur_dir]=1.
  - YELLOW: yellow[cur_dir]=1.
  - ALLRED and WALK: all red=1.
  - Every direction not served shows red.
  - ped_walk=1 only in WALK.
- Lamp invariants:
  - Every direction shows exactly one of green/yellow/red on every clock.
  - At most one direction is non-red at any time.
- ped_pending:
  - Set on any clock with ped_button=1 while phase!=WALK.
  - Cleared on the clock that enters WALK.
  - Presses during WALK are ignored.
  - If set and clear coincide (press on the entering clock), clear wins.
- Actuated mode: direction 0 is always served, so the main street is never starved; with no demand it re-greens after yellow+all-red. veh_demand is not latched.
- Reset mid-phase: immediate return to the reset state; the pending pedestrian request is lost.

Decomposition:
- Shared package traffic_pkg holds:
  - phase_t enum (GREEN=2'd0, YELLOW=2'd1, ALLRED=2'd2, WALK=2'd3);
  - a helper function for duration lookup by phase.
- Sub-module phase_timer:
  - loadable CNT_W down-counter;
  - ports clk, reset, load, load_val, tick; output done = tick & (count==0).
- The controller instantiates one phase_timer.

Test Plan:
Defaults for all scenarios: NUM_DIRS=2, GREEN=4, YELLOW=2, ALLRED=1, WALK=3, tick=1 every clock.
1. Reset release, no requests -> green[0] 4 clks, yellow[0] 2, all-red 1, green[1] 4, yellow[1] 2, all-red 1, then green[0] with new_cycle pulse; period 14 clks; no direction ever has two lamps lit.
2. ped_button pulse during green[1] -> ped_pending=1 next clk. After all-red, WALK 3 clks with ped_walk=1 and red=2'b11. ped_pending=0 from WALK entry. Then green[0] with new_cycle=1.
3. ped_button held high throughout WALK -> ped_pending stays 0 after WALK; the next round has no WALK unless pressed again.
4. ACTUATED=1, NUM_DIRS=3, veh_demand=3'b100 -> greens in order dir0, dir2, dir0. With veh_demand=0 -> dir0 green repeats, each time preceded by yellow+all-red, and new_cycle pulses every 7 clks.
5. Reset asserted during yellow[0] with ped_pending=1 -> same clk green[0]=1, ped_pending=0, timer reloaded: green lasts a full 4 ticks after release.
6. tick held 0 for 100 clks mid-green with a ped_button press -> lamps unchanged, ped_pending=1. Resuming tick completes the remaining green ticks exactly.
